// File: rtl/key_filter_pkg.sv
// Shared definitions for the key debounce filter: FSM states and default filter length.
package key_filter_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE_HIGH,
    FILTER_DOWN,
    HOLD_LOW,
    FILTER_UP
  } key_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 1 (released key).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_edge.sv
// Debounces an active-low mechanical key and emits one-cycle press/release pulses
// once the synchronized level has been stable for DEBOUNCE_CYCLES samples.
module key_debounce_edge
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic pos_edge,
  output logic neg_edge,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  key_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          key_sync;
  logic          pos_next, neg_next, level_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_HIGH;
      cnt       <= '0;
      pos_edge  <= 1'b0;
      neg_edge  <= 1'b0;
      key_level <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pos_edge  <= pos_next;
      neg_edge  <= neg_next;
      key_level <= level_next;
    end
  end

  // Pulses and level are computed from the transition itself so they register on the same edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pos_next   = 1'b0;
    neg_next   = 1'b0;
    case (state)
      IDLE_HIGH: begin
        cnt_next = '0;
        if (!key_sync) state_next = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (key_sync) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HOLD_LOW;
          cnt_next   = '0;
          neg_next   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLD_LOW: begin
        cnt_next = '0;
        if (key_sync) state_next = FILTER_UP;
      end
      FILTER_UP: begin
        if (!key_sync) begin
          state_next = HOLD_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
          pos_next   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE_HIGH;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == IDLE_HIGH) || (state_next == FILTER_DOWN);
  end

endmodule

// File: tb/tb_key_debounce_edge.sv
// Bench for key_debounce_edge: directed timing checks on an 8-cycle filter and
// randomized bounce stress on a 2-cycle filter, both against a run-length model.
module tb_key_debounce_edge;

  localparam int D_SLOW = 8;
  localparam int D_FAST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8 = 1'b1, key8 = 1'b1;
  logic rst2 = 1'b1, key2 = 1'b1;
  logic pos8, neg8, lvl8;
  logic pos2, neg2, lvl2;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  key_debounce_edge #(.DEBOUNCE_CYCLES(D_SLOW)) dut8 (
    .clk(clk), .rst(rst8), .key_in(key8),
    .pos_edge(pos8), .neg_edge(neg8), .key_level(lvl8)
  );

  key_debounce_edge #(.DEBOUNCE_CYCLES(D_FAST)) dut2 (
    .clk(clk), .rst(rst2), .key_in(key2),
    .pos_edge(pos2), .neg_edge(neg2), .key_level(lvl2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the key_sync stream is key_in delayed by two edges; the debounced
  // level flips once DEBOUNCE_CYCLES+1 consecutive samples disagree with it.
  int dcyc  [2] = '{D_SLOW, D_FAST};
  bit m_h1  [2] = '{1'b1, 1'b1};
  bit m_h2  [2] = '{1'b1, 1'b1};
  bit m_lvl [2] = '{1'b1, 1'b1};
  bit m_pos [2] = '{1'b0, 1'b0};
  bit m_neg [2] = '{1'b0, 1'b0};
  int m_run [2] = '{0, 0};
  bit m_rst [2];
  bit m_key [2];

  always @(posedge clk) begin
    m_rst[0] = rst8; m_key[0] = key8;
    m_rst[1] = rst2; m_key[1] = key2;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 1'b0;
      m_neg[i] = 1'b0;
      if (m_rst[i]) begin
        m_h1[i] = 1'b1; m_h2[i] = 1'b1; m_lvl[i] = 1'b1; m_run[i] = 0;
      end else begin
        if (m_h2[i] != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == dcyc[i] + 1) begin
          m_lvl[i] = m_h2[i];
          m_run[i] = 0;
          m_pos[i] = m_lvl[i];
          m_neg[i] = !m_lvl[i];
        end
        m_h2[i] = m_h1[i];
        m_h1[i] = m_key[i];
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus press/release alternation on the fast DUT.
  bit last_pos2 = 1'b1;
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_d8", {29'd0, pos8, neg8, lvl8}, {29'd0, m_pos[0], m_neg[0], m_lvl[0]});
      checkOutput("model_d2", {29'd0, pos2, neg2, lvl2}, {29'd0, m_pos[1], m_neg[1], m_lvl[1]});
      if (rst2) last_pos2 = 1'b1;
      else if (pos2 || neg2) begin
        checkOutput("alternate_d2", {30'd0, pos2, neg2}, last_pos2 ? 32'd1 : 32'd2);
        last_pos2 = pos2;
      end
    end
  end

  // Drives the slow DUT for n edges; edge 0 is the first edge that samples the new inputs.
  task automatic applyStimulus(input bit r, input bit k, input int n,
                               output int first_neg, output int first_pos,
                               output int n_neg, output int n_pos, output int flip_at);
    logic lvl_start;
    first_neg = -1; first_pos = -1; n_neg = 0; n_pos = 0; flip_at = -1;
    lvl_start = lvl8;
    rst8 = r;
    key8 = k;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (neg8 === 1'b1) begin n_neg++; if (first_neg < 0) first_neg = e; end
      if (pos8 === 1'b1) begin n_pos++; if (first_pos < 0) first_pos = e; end
      if (flip_at < 0 && lvl8 !== lvl_start) flip_at = e;
    end
    #1;
  endtask

  typedef struct {
    bit rst;
    bit key;
    int cycles;
    int neg_at;
    int pos_at;
    int nneg;
    int npos;
    bit lvl_end;
  } vec_t;

  vec_t vecs [7];
  int   fn, fp, nn, np, fl;
  bit   seg_keys [4];
  int   len;
  bit   burst_lvl;

  initial begin
    vecs[0] = '{1'b1, 1'b1,  3, -1, -1, 0, 0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 14, 10, -1, 1, 0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 14, -1, 10, 0, 1, 1'b1};
    vecs[3] = '{1'b0, 1'b0,  5, -1, -1, 0, 0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 12, -1, -1, 0, 0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 14, 10, -1, 1, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 14, -1, 10, 0, 1, 1'b1};
    seg_keys = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk_on = 1'b1;

    fork
      begin : slow_sequences
        for (int v = 0; v < 7; v++) begin
          applyStimulus(vecs[v].rst, vecs[v].key, vecs[v].cycles, fn, fp, nn, np, fl);
          checkOutput($sformatf("row%0d_neg_at", v), fn, vecs[v].neg_at);
          checkOutput($sformatf("row%0d_pos_at", v), fp, vecs[v].pos_at);
          checkOutput($sformatf("row%0d_nneg", v), nn, vecs[v].nneg);
          checkOutput($sformatf("row%0d_npos", v), np, vecs[v].npos);
          checkOutput($sformatf("row%0d_level", v), {31'd0, lvl8}, {31'd0, vecs[v].lvl_end});
          checkOutput($sformatf("row%0d_flip_at", v), fl,
                      (vecs[v].neg_at >= 0) ? vecs[v].neg_at : vecs[v].pos_at);
        end

        for (int s = 0; s < 4; s++) begin
          applyStimulus(1'b0, seg_keys[s], 3, fn, fp, nn, np, fl);
          checkOutput($sformatf("bounce_seg%0d_pulses", s), nn + np, 0);
        end
        applyStimulus(1'b0, 1'b0, 14, fn, fp, nn, np, fl);
        checkOutput("bounce_neg_at", fn, 10);
        checkOutput("bounce_nneg", nn, 1);
        checkOutput("bounce_npos", np, 0);
        applyStimulus(1'b0, 1'b1, 14, fn, fp, nn, np, fl);
        checkOutput("bounce_release_pos_at", fp, 10);
        checkOutput("bounce_release_npos", np, 1);

        applyStimulus(1'b0, 1'b0, 7, fn, fp, nn, np, fl);
        checkOutput("midfilter_cnt", {29'd0, dut8.cnt}, 32'd4);
        checkOutput("midfilter_pulses", nn + np, 0);
        applyStimulus(1'b1, 1'b0, 2, fn, fp, nn, np, fl);
        checkOutput("reset_pulses", nn + np, 0);
        checkOutput("reset_outputs", {29'd0, pos8, neg8, lvl8}, 32'd1);
        applyStimulus(1'b0, 1'b0, 14, fn, fp, nn, np, fl);
        checkOutput("post_reset_neg_at", fn, 10);
        checkOutput("post_reset_nneg", nn, 1);
        applyStimulus(1'b0, 1'b1, 14, fn, fp, nn, np, fl);
        checkOutput("post_reset_pos_at", fp, 10);
      end

      begin : fast_stress
        rst2 = 1'b0;
        for (int b = 0; b < 400; b++) begin
          len = $urandom_range(1, 8);
          burst_lvl = 1'($urandom_range(0, 1));
          rst2 = ($urandom_range(0, 39) == 0);
          for (int j = 0; j < len; j++) begin
            key2 = burst_lvl;
            @(negedge clk);
            #1;
            rst2 = 1'b0;
          end
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
